// File: rtl/divmod_pkg.sv
// Shared types and constants for the signed idiv/irem controller and its unsigned divmod core.
package divmod_pkg;

  localparam int unsigned DIVMOD_WIDTH_DEFAULT = 32;

  typedef enum logic {
    OP_DIV = 1'b0,
    OP_REM = 1'b1
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    FIX
  } sdiv_state_e;

endpackage

// File: rtl/divmod.sv
// Unsigned restoring divider: one quotient bit per cycle, done pulses WIDTH+1 cycles after
// trigger. Quotient and remainder are held until the next trigger.
module divmod
  import divmod_pkg::*;
#(
  parameter int unsigned WIDTH = DIVMOD_WIDTH_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic             run_q, run_d;
  logic             done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    done_d  = 1'b0;
    shifted = {rem_q, quo_q[WIDTH-1]};
    // MSB of the difference doubles as the borrow: set means shifted < divisor.
    diff    = shifted - {1'b0, div_q};
    if (run_q) begin
      if (diff[WIDTH]) begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_d = diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end else if (trigger_i) begin
      run_d = 1'b1;
      cnt_d = CntW'(WIDTH);
      quo_d = dividend_i;
      rem_d = '0;
      div_d = divisor_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q  <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else begin
      run_q  <= run_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/sdivmod_ctrl.sv
// Signed idiv/irem controller (Java semantics) around the unsigned divmod core.
// Define SDIVMOD_FASTPATH_EN to resolve b==1, b==-1 and a==0 without starting the divider.
module sdivmod_ctrl
  import divmod_pkg::*;
#(
  parameter int unsigned WIDTH = DIVMOD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  sdiv_state_e      state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] ua_q, ua_d, ub_q, ub_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             fast_q, fast_d;
  logic             wait_arm_q, wait_arm_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic             div_trig;
  logic             div_done;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic [WIDTH-1:0] uq, ur;
  logic             sq, sr;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    ua_d       = ua_q;
    ub_d       = ub_q;
    result_d   = result_q;
    fast_d     = fast_q;
    wait_arm_d = wait_arm_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    div_trig   = 1'b0;
    // Fast path reuses |a| as the unsigned quotient with a zero remainder.
    uq         = fast_q ? ua_q : div_quo;
    ur         = fast_q ? '0 : div_rem;
    sq         = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    sr         = a_q[WIDTH-1];

    unique case (state_q)
      IDLE: begin
        // done_q marks the done cycle, in which a new trigger is not taken.
        if (trigger && !done_q) begin
          a_d        = a;
          b_d        = b;
          op_d       = op_e'(op);
          div_zero_d = 1'b0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        fast_d = 1'b0;
        ua_d   = a_q[WIDTH-1] ? -a_q : a_q;
        ub_d   = b_q[WIDTH-1] ? -b_q : b_q;
        if (b_q == '0) begin
          div_zero_d = 1'b1;
          state_d    = FIX;
        end else begin
`ifdef SDIVMOD_FASTPATH_EN
          if (b_q == WIDTH'(1) || b_q == '1 || a_q == '0) begin
            fast_d  = 1'b1;
            state_d = FIX;
          end else begin
            state_d = START;
          end
`else
          state_d = START;
`endif
        end
      end
      START: begin
        div_trig   = 1'b1;
        wait_arm_d = 1'b0;
        state_d    = WAIT;
      end
      WAIT: begin
        // First WAIT cycle masks any done left over from before a reset.
        if (!wait_arm_q) begin
          wait_arm_d = 1'b1;
        end else if (div_done) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (div_zero_q) begin
          result_d = '0;
        end else if (op_q == OP_DIV) begin
          result_d = sq ? -uq : uq;
        end else begin
          result_d = sr ? -ur : ur;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= OP_DIV;
      a_q        <= '0;
      b_q        <= '0;
      ua_q       <= '0;
      ub_q       <= '0;
      result_q   <= '0;
      fast_q     <= 1'b0;
      wait_arm_q <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ua_q       <= ua_d;
      ub_q       <= ub_d;
      result_q   <= result_d;
      fast_q     <= fast_d;
      wait_arm_q <= wait_arm_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

  divmod #(
    .WIDTH(WIDTH)
  ) u_divmod (
    .clk_i       (clk),
    .rst_i       (rst),
    .trigger_i   (div_trig),
    .dividend_i  (ua_q),
    .divisor_i   (ub_q),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );

  assign busy     = (state_q != IDLE) || done_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_sdivmod_ctrl.sv
// Self-checking bench for sdivmod_ctrl: directed Java idiv/irem cases plus randomized ops
// against a plain-arithmetic reference. Honours SDIVMOD_FASTPATH_EN for expected latency.
module tb_sdivmod_ctrl;

  localparam int W          = 32;
  localparam int DIVMOD_LAT = W + 1;
  localparam int TIMEOUT    = 200;
  localparam logic [31:0] MIN_V = 32'h8000_0000;

  localparam int NDIR = 10;
  localparam logic [31:0] DX [NDIR] = '{32'd12345, -32'sd7, 32'd7, -32'sd7, 32'h8000_0000,
                                        32'd100, 32'd5, 32'd0, -32'sd5, 32'h8000_0000};
  localparam logic [31:0] DY [NDIR] = '{32'd10, 32'd2, -32'sd2, -32'sd2, -32'sd1,
                                        32'd7, 32'd1, -32'sd9, -32'sd1, 32'd1};
  localparam logic [31:0] DQ [NDIR] = '{32'd1234, -32'sd3, -32'sd3, 32'd3, 32'h8000_0000,
                                        32'd14, 32'd5, 32'd0, 32'd5, 32'h8000_0000};
  localparam logic [31:0] DR [NDIR] = '{32'd5, -32'sd1, 32'd1, -32'sd1, 32'd0,
                                        32'd2, 32'd0, 32'd0, 32'd0, 32'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trigger = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_zero;
  logic [31:0] result;

  int n_tests = 0;
  int n_fail  = 0;

  sdivmod_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .trigger  (trigger),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_result(input logic [31:0] x, input logic [31:0] y,
                                             input logic o);
    int sx, sy;
    sx = x;
    sy = y;
    if (y == 0) return 32'd0;
    if (x == MIN_V && y == 32'hffff_ffff) return o ? 32'd0 : MIN_V;
    return o ? sx % sy : sx / sy;
  endfunction

  function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 3;
`ifdef SDIVMOD_FASTPATH_EN
    if (y == 32'd1 || y == 32'hffff_ffff || x == 0) return 3;
`endif
    return 4 + DIVMOD_LAT;
  endfunction

  // Issues one op and measures it; lat counts clock edges from the accepting edge to done.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic o,
                        output logic [31:0] res, output logic dz, output int lat,
                        output int ntrig, output logic busy_ok, output logic [1:0] after);
    @(negedge clk);
    trigger = 1'b1;
    a = x;
    b = y;
    op = o;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 1'($urandom);
    lat = 1;
    ntrig = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      if (dut.div_trig === 1'b1) ntrig++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    res = result;
    dz = div_zero;
    @(posedge clk);
    #1;
    after = {done, busy};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    trigger = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy/done/dz=%b want 000", {busy, done, div_zero});
    end
    n_tests++;
    if (result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    n_tests++;
    if (dut.div_trig !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_div_trig: got %b want 0", dut.div_trig);
    end
    @(negedge clk);
    trigger = 1'b0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [31:0] res, want;
    logic        dz, bok;
    logic [1:0]  aft;
    int          lat, ntrig, el;
    for (int i = 0; i < NDIR; i++) begin
      for (int o = 0; o < 2; o++) begin
        run_op(DX[i], DY[i], 1'(o), res, dz, lat, ntrig, bok, aft);
        want = (o == 0) ? DQ[i] : DR[i];
        el = exp_lat(DX[i], DY[i]);
        n_tests++;
        if (res !== want) begin
          n_fail++;
          $display("FAIL dir_result[%0d op%0d]: got %h want %h", i, o, res, want);
        end
        n_tests++;
        if (dz !== 1'b0) begin
          n_fail++;
          $display("FAIL dir_dz[%0d op%0d]: got %b want 0", i, o, dz);
        end
        n_tests++;
        if (lat != el) begin
          n_fail++;
          $display("FAIL dir_latency[%0d op%0d]: got %0d want %0d", i, o, lat, el);
        end
        n_tests++;
        if (ntrig != ((el == 3) ? 0 : 1)) begin
          n_fail++;
          $display("FAIL dir_div_starts[%0d op%0d]: got %0d want %0d", i, o, ntrig,
                   (el == 3) ? 0 : 1);
        end
        n_tests++;
        if (bok !== 1'b1 || aft !== 2'b00) begin
          n_fail++;
          $display("FAIL dir_busy_pulse[%0d op%0d]: got busy_ok=%b done/busy_after=%b want 1/00",
                   i, o, bok, aft);
        end
      end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    logic        dz, bok;
    logic [1:0]  aft;
    int          lat, ntrig;
    logic [31:0] xs [3] = '{32'd42, -32'sd5, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      for (int o = 0; o < 2; o++) begin
        run_op(xs[i], 32'd0, 1'(o), res, dz, lat, ntrig, bok, aft);
        n_tests++;
        if (res !== 32'd0 || dz !== 1'b1) begin
          n_fail++;
          $display("FAIL dz_result[%0d op%0d]: got %h/%b want 0/1", i, o, res, dz);
        end
        n_tests++;
        if (lat != 3 || ntrig != 0) begin
          n_fail++;
          $display("FAIL dz_timing[%0d op%0d]: got lat=%0d starts=%0d want 3/0", i, o, lat, ntrig);
        end
      end
    end
    run_op(32'd42, 32'd6, 1'b0, res, dz, lat, ntrig, bok, aft);
    n_tests++;
    if (dz !== 1'b0 || res !== 32'd7) begin
      n_fail++;
      $display("FAIL dz_clears: got %h/%b want 7/0", res, dz);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    logic        dz, bok;
    logic [1:0]  aft;
    int          lat, ntrig;
    run_op(32'd1000, 32'd3, 1'b0, res, dz, lat, ntrig, bok, aft);
    @(negedge clk);
    trigger = 1'b1;
    a = 32'd1000;
    b = 32'd3;
    op = 1'b0;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, div_zero} !== 3'b000 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs: got busy/done/dz=%b result=%h want 000/0",
               {busy, done, div_zero}, result);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int o = 0; o < 2; o++) begin
      run_op(32'd100, 32'd7, 1'(o), res, dz, lat, ntrig, bok, aft);
      n_tests++;
      if (res !== ((o == 0) ? 32'd14 : 32'd2)) begin
        n_fail++;
        $display("FAIL midrst_result[op%0d]: got %h want %h", o, res, (o == 0) ? 32'd14 : 32'd2);
      end
      n_tests++;
      if (lat != 4 + DIVMOD_LAT || ntrig != 1) begin
        n_fail++;
        $display("FAIL midrst_timing[op%0d]: got lat=%0d starts=%0d want %0d/1", o, lat, ntrig,
                 4 + DIVMOD_LAT);
      end
    end
  endtask

  task automatic test_trigger_held();
    int          ndone = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    trigger = 1'b1;
    a = 32'd12345;
    b = 32'd10;
    op = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        ndone++;
        res = result;
      end
      if (i == 9) trigger = 1'b0;
    end
    n_tests++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL held_done_count: got %0d want 1", ndone);
    end
    n_tests++;
    if (res !== 32'd1234) begin
      n_fail++;
      $display("FAIL held_result: got %h want %h", res, 32'd1234);
    end
  endtask

  task automatic test_back_to_back();
    int   lat = 0;
    logic seen;
    @(negedge clk);
    trigger = 1'b1;
    a = 32'd200;
    b = 32'd9;
    op = 1'b0;
    @(posedge clk);
    #1;
    trigger = 1'b0;
    while (done !== 1'b1 && lat < TIMEOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_tests++;
    if (done !== 1'b1 || result !== 32'd22) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b result=%h want 1/%h", done, result, 32'd22);
    end
    @(negedge clk);
    trigger = 1'b1;
    a = -32'sd200;
    b = 32'd9;
    op = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done_cycle_ignored: got busy=%b want 0", busy);
    end
    @(posedge clk);
    #1;
    trigger = 1'b0;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < TIMEOUT) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    n_tests++;
    if (lat != 4 + DIVMOD_LAT || result !== -32'sd2) begin
      n_fail++;
      $display("FAIL b2b_second: got lat=%0d result=%h want %0d/%h", lat, result,
               4 + DIVMOD_LAT, -32'sd2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] x, y, res, want;
    logic        o, dz, bok;
    logic [1:0]  aft;
    int          lat, ntrig, el, t;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: x = $urandom;
        1: begin t = int'($urandom_range(0, 200)) - 100; x = t; end
        2: x = MIN_V;
        default: x = 32'd0;
      endcase
      case ($urandom_range(0, 5))
        0, 1: y = $urandom;
        2: begin t = int'($urandom_range(0, 40)) - 20; y = t; end
        3: y = 32'd0;
        4: y = 32'd1;
        default: y = 32'hffff_ffff;
      endcase
      o = 1'($urandom);
      run_op(x, y, o, res, dz, lat, ntrig, bok, aft);
      want = ref_result(x, y, o);
      el = exp_lat(x, y);
      n_tests++;
      if (res !== want || dz !== (y == 0)) begin
        n_fail++;
        $display("FAIL rnd_result[%0d] %h op%0d %h: got %h/%b want %h/%b", i, x, o, y, res, dz,
                 want, (y == 0));
      end
      n_tests++;
      if (lat != el || ntrig != ((el == 3) ? 0 : 1)) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d]: got lat=%0d starts=%0d want %0d/%0d", i, lat, ntrig, el,
                 (el == 3) ? 0 : 1);
      end
      n_tests++;
      if (bok !== 1'b1 || aft !== 2'b00) begin
        n_fail++;
        $display("FAIL rnd_busy_pulse[%0d]: got busy_ok=%b done/busy_after=%b want 1/00", i, bok,
                 aft);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_op();
    test_div_zero();
    test_trigger_held();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
